// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a small byte FIFO.
// Back-to-back queued bytes go out as contiguous frames with no idle gap between them.
module uart_tx #(
    parameter int CLKS_PER_BIT = 3,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       soft_rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       tx_data_out,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       wr_overflow
);

    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = FIFO_DEPTH + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // Byte queue
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;

    assign push = wr_en & ~fifo_full;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            fifo_full   <= 1'b0;
            fifo_empty  <= 1'b1;
            wr_overflow <= 1'b0;
        end else if (soft_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            fifo_full   <= 1'b0;
            fifo_empty  <= 1'b1;
            wr_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count       <= count_next;
            fifo_full   <= (count_next == CNT_FULL);
            fifo_empty  <= (count_next == '0);
            wr_overflow <= wr_en & fifo_full;
        end
    end

    // NOTE: storage has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push && !soft_rst) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    state_t            state;
    state_t            state_next;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_next;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_next;
    logic [7:0]        tx_byte;
    logic [7:0]        byte_next;
    logic              line_next;
    logic              done_next;
    logic              baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign tx_busy   = (state != IDLE);

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        byte_next  = tx_byte;
        line_next  = tx_data_out;
        done_next  = 1'b0;
        pop        = 1'b0;

        case (state)
            IDLE: begin
                line_next = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    byte_next  = mem[rd_ptr];
                    line_next  = 1'b0;
                    baud_next  = '0;
                    state_next = START;
                end
            end

            START: begin
                if (baud_last) begin
                    baud_next  = '0;
                    bit_next   = 3'd0;
                    line_next  = tx_byte[0];
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end

            DATA: begin
                if (baud_last) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        line_next  = 1'b1;
                        state_next = STOP;
                    end else begin
                        bit_next  = bit_idx + 3'd1;
                        line_next = tx_byte[bit_idx + 3'd1];
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end

            STOP: begin
                if (baud_last) begin
                    baud_next = '0;
                    done_next = 1'b1;
                    // Chain straight into the next start bit when more data is waiting.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        byte_next  = mem[rd_ptr];
                        line_next  = 1'b0;
                        state_next = START;
                    end else begin
                        line_next  = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end

            default: begin
                line_next  = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= 3'd0;
            tx_byte     <= 8'h00;
            tx_data_out <= 1'b1;
            tx_done     <= 1'b0;
        end else if (soft_rst) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= 3'd0;
            tx_byte     <= 8'h00;
            tx_data_out <= 1'b1;
            tx_done     <= 1'b0;
        end else begin
            state       <= state_next;
            baud_cnt    <= baud_next;
            bit_idx     <= bit_next;
            tx_byte     <= byte_next;
            tx_data_out <= line_next;
            tx_done     <= done_next;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a serial-line decoder pops expected bytes from a scoreboard,
// while the main sequence checks line timing, flags and reset behaviour cycle by cycle.
module tb_uart_tx;

    localparam int CPB   = 3;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       soft_rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_data_out;
    logic       tx_busy;
    logic       tx_done;
    logic       fifo_full;
    logic       fifo_empty;
    logic       wr_overflow;

    uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .soft_rst   (soft_rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .tx_data_out(tx_data_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .wr_overflow(wr_overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j >= 9) return 1'b1;
        return b[j-1];
    endfunction

    // Serial decoder: samples mid-bit, checks framing and compares against the scoreboard.
    logic       mon_en    = 1'b0;
    logic       rx_active = 1'b0;
    int         rx_cnt    = 0;
    int         rx_frames = 0;
    logic [7:0] rx_byte   = 8'h00;

    always @(negedge clk) begin
        logic [8:0] exp_byte;
        int         b;
        if (!mon_en) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx_data_out === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
            end
        end else begin
            rx_cnt++;
        end
        if (mon_en && rx_active && (rx_cnt % CPB) == (CPB / 2)) begin
            b = rx_cnt / CPB;
            if (b == 0) begin
                check("rx_start_bit", tx_data_out, 1'b0);
            end else if (b <= 8) begin
                rx_byte[b-1] = tx_data_out;
            end else begin
                check("rx_stop_bit", tx_data_out, 1'b1);
                exp_byte = (sb.size() != 0) ? {1'b0, sb.pop_front()} : 9'h100;
                check("rx_byte", {1'b0, rx_byte}, exp_byte);
                rx_frames++;
                rx_active = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] burst [5];
        logic [7:0] b;
        int         f;
        int         j;
        int         sent;
        int         waited;
        int         frames_before;

        burst[0] = 8'h00;
        burst[1] = 8'hFF;
        burst[2] = 8'h55;
        burst[3] = 8'h3C;
        burst[4] = 8'h81;

        rst      = 1'b0;
        soft_rst = 1'b0;
        wr_en    = 1'b0;
        wr_data  = 8'h00;

        // Hard reset held while writes are strobed: nothing may move.
        for (int i = 0; i < 36; i++) begin
            wr_en   = i[0];
            wr_data = i[7:0];
            @(negedge clk);
            check("rst_line", tx_data_out, 1'b1);
            check("rst_busy", tx_busy, 1'b0);
            check("rst_empty", fifo_empty, 1'b1);
        end
        wr_en = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        check("rst_done", tx_done, 1'b0);
        check("rst_full", fifo_full, 1'b0);
        check("rst_overflow", wr_overflow, 1'b0);
        check("rst_empty_after", fifo_empty, 1'b1);

        // Single frame 0xA5.
        mon_en  = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        sb.push_back(8'hA5);
        @(negedge clk);
        wr_en = 1'b0;
        check("single_queued", fifo_empty, 1'b0);
        check("single_idle_busy", tx_busy, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            check("single_line", tx_data_out, frame_bit(8'hA5, (k - 1) / CPB));
            check("single_busy", tx_busy, 1'b1);
            check("single_done_low", tx_done, 1'b0);
            check("single_empty", fifo_empty, 1'b1);
        end
        @(negedge clk);
        check("single_done", tx_done, 1'b1);
        check("single_end_busy", tx_busy, 1'b0);
        check("single_end_line", tx_data_out, 1'b1);
        @(negedge clk);
        check("single_done_pulse", tx_done, 1'b0);
        check("single_sb_drained", sb.size(), 0);

        // Burst of five bytes plus one dropped write; frames must be contiguous.
        for (int k = 0; k <= 151; k++) begin
            wr_en = (k <= 5);
            if (k < 5) begin
                wr_data = burst[k];
                sb.push_back(burst[k]);
            end else if (k == 5) begin
                wr_data = 8'hEE;
            end
            @(negedge clk);
            wr_en = 1'b0;
            if (k == 3) check("burst_not_full", fifo_full, 1'b0);
            if (k == 4) check("burst_full", fifo_full, 1'b1);
            if (k == 5) begin
                check("burst_overflow", wr_overflow, 1'b1);
                check("burst_full_held", fifo_full, 1'b1);
            end
            if (k == 6) check("burst_overflow_pulse", wr_overflow, 1'b0);
            if (k >= 1 && k <= 150) begin
                f = (k - 1) / 30;
                j = ((k - 1) % 30) / CPB;
                b = burst[f];
                check("burst_line", tx_data_out, frame_bit(b, j));
                check("burst_busy", tx_busy, 1'b1);
                check("burst_done", tx_done, (k > 1 && (k - 1) % 30 == 0));
            end
            if (k == 151) begin
                check("burst_last_done", tx_done, 1'b1);
                check("burst_end_busy", tx_busy, 1'b0);
                check("burst_end_line", tx_data_out, 1'b1);
                check("burst_end_empty", fifo_empty, 1'b1);
            end
        end
        @(negedge clk);
        check("burst_done_pulse", tx_done, 1'b0);
        check("burst_sb_drained", sb.size(), 0);

        // Soft reset during data bit 3 of 0x3C with two bytes still queued.
        mon_en = 1'b0;
        for (int k = 0; k <= 14; k++) begin
            wr_en    = (k <= 2) || (k == 14);
            soft_rst = (k == 14);
            wr_data  = (k == 0) ? 8'h3C : (k == 1) ? 8'h11 : (k == 2) ? 8'h22 : 8'h77;
            @(negedge clk);
            wr_en    = 1'b0;
            soft_rst = 1'b0;
            if (k == 2) check("abort_two_queued", fifo_empty, 1'b0);
            if (k >= 1 && k <= 13) begin
                check("abort_line", tx_data_out, frame_bit(8'h3C, (k - 1) / CPB));
                check("abort_busy", tx_busy, 1'b1);
            end
            if (k == 14) begin
                check("abort_line_high", tx_data_out, 1'b1);
                check("abort_busy_low", tx_busy, 1'b0);
                check("abort_empty", fifo_empty, 1'b1);
                check("abort_full", fifo_full, 1'b0);
                check("abort_no_done", tx_done, 1'b0);
                check("abort_no_overflow", wr_overflow, 1'b0);
            end
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check("post_abort_line", tx_data_out, 1'b1);
            check("post_abort_busy", tx_busy, 1'b0);
            check("post_abort_done", tx_done, 1'b0);
            check("post_abort_empty", fifo_empty, 1'b1);
        end

        // Every byte value through the decoder, writing whenever the queue has room.
        mon_en        = 1'b1;
        frames_before = rx_frames;
        sent          = 0;
        waited        = 0;
        while ((sent < 256 || sb.size() != 0) && waited < 9000) begin
            if (sent < 256 && fifo_full === 1'b0) begin
                wr_en   = 1'b1;
                wr_data = sent[7:0];
                sb.push_back(sent[7:0]);
                sent++;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
            waited++;
        end
        wr_en = 1'b0;
        check("sweep_sb_drained", sb.size(), 0);
        check("sweep_frames", rx_frames - frames_before, 256);
        repeat (4) @(negedge clk);
        check("sweep_idle_line", tx_data_out, 1'b1);
        check("sweep_idle_busy", tx_busy, 1'b0);

        // Asynchronous reset mid-frame takes effect without a clock edge.
        mon_en  = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'h5A;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (5) @(negedge clk);
        check("async_busy_before", tx_busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("async_line", tx_data_out, 1'b1);
        check("async_busy", tx_busy, 1'b0);
        check("async_empty", fifo_empty, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("async_stay_idle", tx_busy, 1'b0);
        check("async_stay_line", tx_data_out, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 3: clock cycles each serial bit is held; legal values >= 2.
REQ-002 Parameter FIFO_DEPTH, default 4: number of entries in the byte queue; power of two, >= 2.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port soft_rst, input, 1 bit: synchronous, active-high abort and flush.
REQ-006 Port wr_en, input, 1 bit: byte-write strobe.
REQ-007 Port wr_data, input, 8 bits: byte to queue.
REQ-008 Port tx_data_out, output, 1 bit: registered serial line; idle high; drives UART_RX tx_data_out.
REQ-009 Port tx_busy, output, 1 bit: high while a frame is on the line.
REQ-010 Port tx_done, output, 1 bit: one-cycle pulse per completed frame.
REQ-011 Port fifo_full, output, 1 bit: queue holds FIFO_DEPTH bytes.
REQ-012 Port fifo_empty, output, 1 bit: queue holds 0 bytes.
REQ-013 Port wr_overflow, output, 1 bit: one-cycle pulse when a write is dropped.

Function
REQ-014 Frame format SHALL be 8N1: start bit 0, data[0] through data[7] LSB first, stop bit 1; 10 bits of CLKS_PER_BIT cycles each, 10*CLKS_PER_BIT cycles per frame.
REQ-015 The FSM SHALL have states IDLE, START, DATA and STOP; DATA uses a 3-bit bit index and a baud counter running 0..CLKS_PER_BIT-1.
REQ-016 IDLE -> START SHALL occur on the edge where the state is IDLE and fifo_empty=0; on that edge the head byte is popped into a shift register and tx_data_out becomes 0.
REQ-017 START -> DATA SHALL occur after CLKS_PER_BIT cycles; DATA -> STOP after 8 bits; STOP ends after CLKS_PER_BIT cycles.
REQ-018 At the end of STOP, with fifo_empty=0, the FSM SHALL go straight to START and pop the next byte, leaving no idle-high gap between frames.
REQ-019 At the end of STOP, with fifo_empty=1, the FSM SHALL go to IDLE with tx_data_out=1.
REQ-020 tx_busy SHALL be 1 exactly in START, DATA and STOP.
REQ-021 tx_done SHALL be 1 for the single cycle after the last stop-bit cycle.
REQ-022 For back-to-back frames, tx_done SHALL coincide with the first start-bit cycle of the next frame.
REQ-023 A write SHALL be accepted iff wr_en=1 and fifo_full=0 in that cycle.
REQ-024 A write with wr_en=1 and fifo_full=1 SHALL be dropped: queue unchanged, wr_overflow=1 on the next cycle.
REQ-025 A write and a pop on the same edge SHALL both take effect and leave occupancy unchanged, provided the write is accepted under REQ-023.
REQ-026 The read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 The occupancy count SHALL be FIFO_DEPTH plus 1 bits wide.
REQ-028 fifo_full and fifo_empty SHALL be derived from the occupancy count registered on the same edge.
REQ-029 wr_data sampled while the FSM is busy SHALL NOT disturb the frame in flight.

Reset
REQ-030 When rst=0, regardless of clk, the block SHALL force: state IDLE, tx_data_out=1, tx_busy=0, tx_done=0, wr_overflow=0, fifo_empty=1, fifo_full=0, pointers and counters 0.
REQ-031 When soft_rst=1 on an edge, the block SHALL apply the same values as REQ-030 and ignore wr_en in that cycle.
REQ-032 A soft reset mid-frame SHALL abort the frame with the line high on the next cycle and no tx_done pulse.
REQ-033 soft_rst SHALL dominate wr_en and the FSM; rst SHALL dominate everything.

Verification (CLKS_PER_BIT=3, FIFO_DEPTH=4)
REQ-034 Hold rst=0 for 36 cycles while pulsing wr_en -> tx_data_out=1, tx_busy=0, fifo_empty=1 throughout.
REQ-035 Write 0xA5 at edge N -> line reads 0,1,0,1,0,0,1,0,1,1, each for 3 cycles, over N+1..N+30; tx_busy=1 over that window; tx_done=1 only at N+31; fifo_empty=1 from N+1.
REQ-036 Write 0x00, 0xFF, 0x55, 0x3C, 0x81 at N..N+4 -> fifo_full=1 after N+4; a sixth write at N+5 gives wr_overflow=1 at N+6; 5 contiguous frames over 150 cycles with no gap; 5 tx_done pulses 30 cycles apart.
REQ-037 Assert soft_rst during data bit 3 of 0x3C with 2 bytes queued -> line 1 next cycle, tx_busy=0, fifo_empty=1, no tx_done, no further frames.
REQ-038 Loop tx_data_out into UART_RX with matching CLKS_PER_BIT and send 0..255 -> each rx_data_out equals the sent byte, one rx_done per byte, error=0.
